// File: rtl/rv_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_runctl_pkg
// Brief   : Shared types and constants for the run/halt/step controller.
// Revision: 1.0 - initial release
// ============================================================================
package rv_runctl_pkg;

  localparam int unsigned CAUSE_W = 2;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DRAIN      = 2'd1,
    HALTED     = 2'd2,
    STEP_ISSUE = 2'd3
  } run_state_e;

  // Reason the core last stopped; visible to the debugger.
  typedef enum logic [CAUSE_W-1:0] {
    NONE = 2'd0,
    REQ  = 2'd1,
    BP   = 2'd2,
    STEP = 2'd3
  } halt_cause_e;

endpackage : rv_runctl_pkg
`default_nettype wire

// File: rtl/rv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rv_run_ctrl
// Brief   : Run/halt/step controller for the 5-stage pipeline. Freezes fetch,
//           kills decode and waits for E/M/W to drain before reporting halted;
//           supports PC breakpoints, multi-instruction stepping and resume
//           with a PC redirect to the last architectural next PC.
// Options : RV_RUNCTL_INSTRET_EN - build the 64-bit retired-instruction counter
//           (otherwise instret reads as zero and no counter flops exist).
// Revision: 1.0 - initial release
// ============================================================================
module rv_run_ctrl
  import rv_runctl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned DRAIN_CYC    = 3,
  parameter bit          START_HALTED = 1'b0,
  parameter int unsigned STEP_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt_req,
  input  logic               resume_req,
  input  logic               step_req,
  input  logic [STEP_W-1:0]  step_n,
  input  logic               bp_en,
  input  logic [31:0]        bp_addr,
  input  logic               id_fire,
  input  logic [31:0]        id_pc,
  input  logic               retire_valid,
  input  logic [31:0]        retire_npc,
  output logic               freeze_f,
  output logic               kill_d,
  output logic               pc_redirect,
  output logic [31:0]        redirect_pc,
  output logic               halted,
  output logic [CAUSE_W-1:0] halt_cause,
  output logic [63:0]        instret
);

  // The drain counter counts DRAIN_CYC-1 down to 0, so it only needs to hold
  // DRAIN_CYC-1.
  localparam int unsigned DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  localparam run_state_e  RST_STATE = START_HALTED ? HALTED : RUN;
  localparam halt_cause_e RST_CAUSE = START_HALTED ? REQ : NONE;

  // A zero-length drain would report halted while E/M/W still hold work.
  if (DRAIN_CYC == 0) begin : g_drain_cyc_check
    $error("rv_run_ctrl: DRAIN_CYC must be at least 1");
  end

  run_state_e        state_q,    state_d;
  halt_cause_e       cause_q,    cause_d;
  logic [DCNT_W-1:0] dcnt_q,     dcnt_d;
  logic [STEP_W-1:0] step_q,     step_d;
  logic              bp_skip_q,  bp_skip_d;
  logic              redirect_q, redirect_d;
  logic              freeze_q,   freeze_d;
  logic              kill_q,     kill_d_d;
  logic              halted_q,   halted_d;
  logic [31:0]       resume_pc_q;
  logic              bp_hit;

  // A breakpoint fires only on a fresh decode; the instruction resumed at is
  // let through once so resuming from a breakpoint makes progress.
  assign bp_hit = id_fire && bp_en && (id_pc == bp_addr) && !bp_skip_q;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    dcnt_d     = dcnt_q;
    step_d     = step_q;
    bp_skip_d  = bp_skip_q;
    redirect_d = 1'b0;

    if (id_fire) begin
      bp_skip_d = 1'b0;
    end

    unique case (state_q)
      RUN: begin
        if (bp_hit) begin
          state_d = DRAIN;
          cause_d = BP;
          dcnt_d  = DRAIN_LOAD;
        end else if (halt_req) begin
          state_d = DRAIN;
          cause_d = REQ;
          dcnt_d  = DRAIN_LOAD;
        end
      end

      DRAIN: begin
        if (dcnt_q == '0) begin
          if (step_q > STEP_ONE) begin
            step_d     = step_q - STEP_ONE;
            state_d    = STEP_ISSUE;
            redirect_d = 1'b1;
            bp_skip_d  = 1'b1;
          end else begin
            state_d = HALTED;
          end
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end

      HALTED: begin
        if (step_req) begin
          step_d     = (step_n == '0) ? STEP_ONE : step_n;
          state_d    = STEP_ISSUE;
          cause_d    = STEP;
          redirect_d = 1'b1;
          bp_skip_d  = 1'b1;
        end else if (resume_req) begin
          state_d    = RUN;
          cause_d    = NONE;
          redirect_d = 1'b1;
          bp_skip_d  = 1'b1;
        end
      end

      STEP_ISSUE: begin
        // A halt during stepping cuts the remaining count so the in-flight
        // instruction drains and the controller stops there.
        if (halt_req) begin
          step_d  = STEP_ONE;
          cause_d = REQ;
        end
        if (id_fire) begin
          state_d = DRAIN;
          dcnt_d  = DRAIN_LOAD;
        end
      end

      default: begin
        state_d = RST_STATE;
      end
    endcase

    freeze_d = (state_d == DRAIN) || (state_d == HALTED);
    kill_d_d = freeze_d;
    halted_d = (state_d == HALTED);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      cause_q    <= RST_CAUSE;
      dcnt_q     <= '0;
      step_q     <= '0;
      bp_skip_q  <= 1'b0;
      redirect_q <= 1'b0;
      freeze_q   <= 1'b0;
      kill_q     <= 1'b0;
      halted_q   <= START_HALTED;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      dcnt_q     <= dcnt_d;
      step_q     <= step_d;
      bp_skip_q  <= bp_skip_d;
      redirect_q <= redirect_d;
      freeze_q   <= freeze_d;
      kill_q     <= kill_d_d;
      halted_q   <= halted_d;
    end
  end

  // Resume PC tracks the architectural next PC of every retirement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resume_pc_q <= RESET_PC;
    end else if (retire_valid) begin
      resume_pc_q <= retire_npc;
    end
  end

`ifdef RV_RUNCTL_INSTRET_EN
  logic [63:0] instret_q;

  // Free-running retired-instruction counter; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire_valid) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

  assign freeze_f    = freeze_q;
  assign kill_d      = kill_q;
  assign pc_redirect = redirect_q;
  assign redirect_pc = resume_pc_q;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;

endmodule : rv_run_ctrl
`default_nettype wire

// File: tb/tb_rv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_run_ctrl
// Brief   : Self-checking bench for rv_run_ctrl: directed vector table,
//           hand-written stepping/reset sequences and randomized traffic
//           against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv_run_ctrl;

  localparam int unsigned DRAIN_CYC = 3;
  localparam logic [31:0] BP_PC     = 32'h40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
  logic [7:0]  step_n = '0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = BP_PC;
  logic        id_fire = 1'b0;
  logic [31:0] id_pc = '0;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_npc = '0;
  logic        freeze_f, kill_d, pc_redirect, halted;
  logic [31:0] redirect_pc;
  logic [1:0]  halt_cause;
  logic [63:0] instret;

  rv_run_ctrl #(
    .RESET_PC(32'h0), .DRAIN_CYC(DRAIN_CYC), .START_HALTED(1'b0), .STEP_W(8)
  ) dut (
    .clk(clk), .reset(reset), .halt_req(halt_req), .resume_req(resume_req),
    .step_req(step_req), .step_n(step_n), .bp_en(bp_en), .bp_addr(bp_addr),
    .id_fire(id_fire), .id_pc(id_pc), .retire_valid(retire_valid),
    .retire_npc(retire_npc), .freeze_f(freeze_f), .kill_d(kill_d),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .halted(halted),
    .halt_cause(halt_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the controller is seen as "draining for N more
  // cycles", "halted", "waiting for the step instruction" or running.
  int          m_drain_left;
  bit          m_halted, m_issuing, m_skip, m_redirect;
  int          m_steps_left;
  int          m_cause;
  logic [31:0] m_rpc;
  longint unsigned m_instret;

  task automatic model_reset();
    m_drain_left = 0; m_halted = 0; m_issuing = 0; m_skip = 0; m_redirect = 0;
    m_steps_left = 0; m_cause = 0; m_rpc = 32'h0; m_instret = 0;
  endtask

  task automatic model_step();
    bit skip_next;
    m_redirect = 0;
    if (retire_valid) begin
      m_rpc = retire_npc;
      m_instret++;
    end
    skip_next = id_fire ? 1'b0 : m_skip;
    if (m_drain_left > 0) begin
      m_drain_left--;
      if (m_drain_left == 0) begin
        if (m_steps_left > 1) begin
          m_steps_left--; m_issuing = 1; m_redirect = 1; skip_next = 1;
        end else begin
          m_halted = 1;
        end
      end
    end else if (m_halted) begin
      if (step_req) begin
        m_steps_left = (step_n == 0) ? 1 : int'(step_n);
        m_halted = 0; m_issuing = 1; m_cause = 3; m_redirect = 1; skip_next = 1;
      end else if (resume_req) begin
        m_halted = 0; m_cause = 0; m_redirect = 1; skip_next = 1;
      end
    end else if (m_issuing) begin
      if (halt_req) begin
        m_steps_left = 1; m_cause = 1;
      end
      if (id_fire) begin
        m_issuing = 0; m_drain_left = DRAIN_CYC;
      end
    end else begin
      if (id_fire && bp_en && id_pc == bp_addr && !m_skip) begin
        m_drain_left = DRAIN_CYC; m_cause = 2;
      end else if (halt_req) begin
        m_drain_left = DRAIN_CYC; m_cause = 1;
      end
    end
    m_skip = skip_next;
  endtask

  task automatic model_check();
    logic [63:0] exp_ir;
`ifdef RV_RUNCTL_INSTRET_EN
    exp_ir = m_instret;
`else
    exp_ir = 64'd0;
`endif
    chk("model.freeze_f", freeze_f, (m_drain_left > 0) || m_halted);
    chk("model.kill_d", kill_d, (m_drain_left > 0) || m_halted);
    chk("model.halted", halted, m_halted);
    chk("model.pc_redirect", pc_redirect, m_redirect);
    chk("model.halt_cause", halt_cause, m_cause);
    chk("model.redirect_pc", redirect_pc, m_rpc);
    chk("model.instret", instret, exp_ir);
  endtask

  // One clock: inputs already driven, model follows the edge, outputs
  // sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic clear_inputs();
    halt_req = 0; resume_req = 0; step_req = 0; step_n = 0;
    id_fire = 0; id_pc = 0; retire_valid = 0; retire_npc = 0;
  endtask

  typedef struct {
    logic        hr, rr, sr;
    logic [7:0]  sn;
    logic        bpe, idf;
    logic [31:0] idpc;
    logic        rv;
    logic [31:0] npc;
    logic        e_frz, e_halt, e_redir;
    logic [1:0]  e_cause;
    logic [31:0] e_rpc;
  } vec_t;

  function automatic vec_t mk(input logic hr, rr, sr, input logic [7:0] sn,
                              input logic bpe, idf, input logic [31:0] idpc,
                              input logic rv, input logic [31:0] npc,
                              input logic efrz, ehalt, eredir,
                              input logic [1:0] ecause, input logic [31:0] erpc);
    vec_t v;
    v.hr = hr; v.rr = rr; v.sr = sr; v.sn = sn; v.bpe = bpe; v.idf = idf;
    v.idpc = idpc; v.rv = rv; v.npc = npc; v.e_frz = efrz; v.e_halt = ehalt;
    v.e_redir = eredir; v.e_cause = ecause; v.e_rpc = erpc;
    return v;
  endfunction

  // Tiny core emulation for stepping: fires one instruction whenever fetch
  // is open and no redirect is in flight, retires it two cycles later.
  task automatic run_steps(input int n, input int halt_after,
                           output int fires, output int rets, output bit timed_out);
    logic [1:0] sr;
    bit pulsed;
    sr = 0; fires = 0; rets = 0; pulsed = 0; timed_out = 1;
    step_req = 1; step_n = 8'(n);
    tick();
    step_req = 0; step_n = 0;
    for (int k = 0; k < 80; k++) begin
      id_fire      = !freeze_f && !pc_redirect;
      id_pc        = 32'h100 + 32'(fires * 4);
      retire_valid = sr[1];
      retire_npc   = 32'h200 + 32'(rets * 4);
      halt_req     = (halt_after >= 0) && !pulsed && (fires == halt_after) && pc_redirect;
      if (halt_req) pulsed = 1;
      if (id_fire) fires++;
      if (retire_valid) rets++;
      tick();
      sr = {sr[0], id_fire};
      if (halted && sr == 2'b00) begin
        timed_out = 0;
        break;
      end
    end
    clear_inputs();
  endtask

  vec_t tv[25];

  initial begin
    int f, r;
    bit to;
    logic [63:0] exp7;

    // Directed sequence: halt request, breakpoint with skip-on-resume,
    // simultaneous step+resume with step_n = 0.
    //            hr rr sr sn bpe idf idpc   rv npc      frz hlt rdr c  rpc
    tv[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 0, 0, 1, 32'h0);
    tv[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  1, 32'h10, 1, 0, 0, 1, 32'h10);
    tv[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  1, 32'h14, 1, 0, 0, 1, 32'h14);
    tv[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  1, 32'h18, 1, 1, 0, 1, 32'h18);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 0, 1, 32'h18);
    tv[5]  = mk(1, 0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 1, 0, 1, 32'h18);
    tv[6]  = mk(0, 1, 0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 1, 0, 32'h18);
    tv[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 32'h18);
    tv[8]  = mk(0, 0, 0, 0, 1, 1, 32'h30, 1, 32'h3C, 0, 0, 0, 0, 32'h3C);
    tv[9]  = mk(1, 0, 0, 0, 1, 1, 32'h40, 1, 32'h40, 1, 0, 0, 2, 32'h40);
    tv[10] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 2, 32'h40);
    tv[11] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 2, 32'h40);
    tv[12] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 1, 0, 2, 32'h40);
    tv[13] = mk(0, 1, 0, 0, 1, 0, 32'h0,  0, 32'h0,  0, 0, 1, 0, 32'h40);
    tv[14] = mk(0, 0, 0, 0, 1, 1, 32'h40, 0, 32'h0,  0, 0, 0, 0, 32'h40);
    tv[15] = mk(0, 0, 0, 0, 1, 1, 32'h40, 0, 32'h0,  1, 0, 0, 2, 32'h40);
    tv[16] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 2, 32'h40);
    tv[17] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 2, 32'h40);
    tv[18] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 1, 0, 2, 32'h40);
    tv[19] = mk(0, 1, 1, 0, 1, 0, 32'h0,  0, 32'h0,  0, 0, 1, 3, 32'h40);
    tv[20] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  0, 0, 0, 3, 32'h40);
    tv[21] = mk(0, 0, 0, 0, 1, 1, 32'h40, 0, 32'h0,  1, 0, 0, 3, 32'h40);
    tv[22] = mk(0, 0, 0, 0, 1, 0, 32'h0,  1, 32'h44, 1, 0, 0, 3, 32'h44);
    tv[23] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 0, 0, 3, 32'h44);
    tv[24] = mk(0, 0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  1, 1, 0, 3, 32'h44);

    model_reset();
    #2;
    chk("reset.freeze_f", freeze_f, 0);
    chk("reset.kill_d", kill_d, 0);
    chk("reset.halted", halted, 0);
    chk("reset.halt_cause", halt_cause, 0);
    chk("reset.redirect_pc", redirect_pc, 32'h0);
    #10;
    reset = 0;

    foreach (tv[i]) begin
      halt_req = tv[i].hr; resume_req = tv[i].rr; step_req = tv[i].sr;
      step_n = tv[i].sn; bp_en = tv[i].bpe; id_fire = tv[i].idf;
      id_pc = tv[i].idpc; retire_valid = tv[i].rv; retire_npc = tv[i].npc;
      tick();
      chk($sformatf("vec%0d.freeze_f", i), freeze_f, tv[i].e_frz);
      chk($sformatf("vec%0d.kill_d", i), kill_d, tv[i].e_frz);
      chk($sformatf("vec%0d.halted", i), halted, tv[i].e_halt);
      chk($sformatf("vec%0d.pc_redirect", i), pc_redirect, tv[i].e_redir);
      chk($sformatf("vec%0d.halt_cause", i), halt_cause, tv[i].e_cause);
      chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, tv[i].e_rpc);
    end
    clear_inputs();
    bp_en = 0;

    // Three-instruction step.
    run_steps(3, -1, f, r, to);
    chk("step3.timeout", to, 0);
    chk("step3.fires", f, 3);
    chk("step3.retires", r, 3);
    chk("step3.halted", halted, 1);
    chk("step3.cause", halt_cause, 3);

    // Halt arriving during the second instruction of a five-step.
    run_steps(5, 1, f, r, to);
    chk("step5h.timeout", to, 0);
    chk("step5h.fires", f, 2);
    chk("step5h.retires", r, 2);
    chk("step5h.halted", halted, 1);
    chk("step5h.cause", halt_cause, 1);

    // Asynchronous reset in the middle of a drain.
    resume_req = 1; tick(); resume_req = 0;
    halt_req = 1; tick(); halt_req = 0;
    tick();
    #3;
    reset = 1;
    #1;
    chk("areset.freeze_f", freeze_f, 0);
    chk("areset.kill_d", kill_d, 0);
    chk("areset.pc_redirect", pc_redirect, 0);
    chk("areset.halted", halted, 0);
    chk("areset.halt_cause", halt_cause, 0);
    chk("areset.redirect_pc", redirect_pc, 32'h0);
    chk("areset.instret", instret, 0);
    model_reset();
    #1;
    reset = 0;

    // Retired-instruction count.
    for (int k = 0; k < 7; k++) begin
      retire_valid = 1; retire_npc = 32'h1000 + 32'(k * 4);
      tick();
    end
    clear_inputs();
`ifdef RV_RUNCTL_INSTRET_EN
    exp7 = 64'd7;
`else
    exp7 = 64'd0;
`endif
    chk("instret.seven", instret, exp7);
    chk("instret.rpc", redirect_pc, 32'h1018);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      halt_req     = ($urandom % 12) == 0;
      resume_req   = ($urandom % 5) == 0;
      step_req     = ($urandom % 7) == 0;
      step_n       = 8'($urandom % 4);
      if (($urandom % 50) == 0) bp_en = ~bp_en;
      id_fire      = ($urandom % 2) == 0;
      case ($urandom % 3)
        0:       id_pc = BP_PC;
        1:       id_pc = BP_PC + 32'h4;
        default: id_pc = $urandom & 32'hFFFF_FFFC;
      endcase
      retire_valid = ($urandom % 2) == 0;
      retire_npc   = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rv_run_ctrl
`default_nettype wire
